// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner/state encoding shared by the memory arbiter files
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_EXT  = 2'd3
    } own_t;

endpackage

// File: rtl/dma_addr_ctr.sv
// dma_addr_ctr: DMA address counter, steps by 2 per completed access, zero load wins
module dma_addr_ctr #(
    parameter int           W        = 16,
    parameter logic [W-1:0] DMA_BASE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         zero,
    output logic [W-1:0] dma_addr
);

    logic [W-1:0] cur;

    // dma_addr is the value the counter takes at the next edge, so a launch in the
    // same cycle as a completion or zero load already sees the updated address
    assign dma_addr = zero ? DMA_BASE : inc ? cur + W'(2) : cur;

    // address register, reloaded with the base on reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            cur <= DMA_BASE;
        else
            cur <= dma_addr;
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: memory arbiter between DMA, CPU and optional external requester
// Define MEM_ARB_EXT_EN to arbitrate the external requester; otherwise it is ignored.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int           W         = 16,
    parameter logic [W-1:0] DMA_BASE  = '0,
    parameter int           DMA_BURST = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rdy,
    input  logic         cpu_req,
    input  logic [W-1:0] cpu_addr,
    input  logic         cpu_word,
    input  logic         cpu_read,
    input  logic         cpu_dbus,
    output logic         cpu_gnt,
    input  logic         dma_req,
    input  logic         zero_req,
    output logic         dma_done,
    input  logic         ext_req,
    input  logic [W-1:0] ext_addr,
    input  logic         ext_word,
    input  logic         ext_read,
    output logic         ext_gnt,
    output logic         mem_ce,
    output logic [W-1:0] addr_nxt,
    output logic         word_nxt,
    output logic         read_nxt,
    output logic         dbus_nxt,
    output logic         dma,
    output logic [1:0]   owner
);

    localparam int CW = $clog2(DMA_BURST + 1);

    own_t          state, nxt, win;
    logic [CW-1:0] burst;
    logic          ext_on, launch, done;
    logic [W-1:0]  dma_addr;

`ifdef MEM_ARB_EXT_EN
    assign ext_on = ext_req;
`else
    logic ext_unused;
    assign ext_on     = 1'b0;
    assign ext_unused = ext_req;
`endif

    dma_addr_ctr #(.W(W), .DMA_BASE(DMA_BASE)) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (dma_done),
        .zero    (zero_req),
        .dma_addr(dma_addr)
    );

    // arbitration, next state and access fields; everything is gated by rst_n so
    // a reset mid-access shows reset values and never emits a complete pulse
    always_comb begin
        launch   = rst_n && (dma_req || cpu_req || ext_on) && (state == OWN_IDLE || rdy);
        done     = rst_n && state != OWN_IDLE && rdy;
        win      = (dma_req && !(cpu_req && burst >= CW'(DMA_BURST))) ? OWN_DMA :
                   cpu_req ? OWN_CPU : ext_on ? OWN_EXT : OWN_IDLE;
        nxt      = launch ? win : done ? OWN_IDLE : state;
        mem_ce   = launch;
        addr_nxt = !launch ? '0 : win == OWN_DMA ? dma_addr : win == OWN_CPU ? cpu_addr : ext_addr;
        word_nxt = !launch || win == OWN_DMA ? 1'b1 : win == OWN_CPU ? cpu_word : ext_word;
        read_nxt = !launch || win == OWN_DMA ? 1'b1 : win == OWN_CPU ? cpu_read : ext_read;
        dbus_nxt = launch && win == OWN_CPU && cpu_dbus;
        cpu_gnt  = done && state == OWN_CPU;
        dma_done = done && state == OWN_DMA;
        ext_gnt  = done && state == OWN_EXT;
        dma      = rst_n && state == OWN_DMA;
        owner    = rst_n ? state : OWN_IDLE;
    end

    // state register and DMA burst counter (counts only while the CPU waits)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OWN_IDLE;
            burst <= '0;
        end else begin
            state <= nxt;
            if (launch)
                burst <= win != OWN_DMA ? '0 : cpu_req ? burst + CW'(1) : burst;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: random and directed stimulus against a behavioural arbiter model
module tb_mem_arb;

`ifdef MEM_ARB_EXT_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, rdy, cpu_req, cpu_word, cpu_read, cpu_dbus, dma_req, zero_req;
    logic        ext_req, ext_word, ext_read;
    logic [15:0] cpu_addr, ext_addr;
    logic        cpu_gnt, dma_done, ext_gnt, mem_ce, word_nxt, read_nxt, dbus_nxt, dma;
    logic [15:0] addr_nxt;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_own;
    int          m_cnt;
    logic [15:0] m_addr;

    logic [9:0]  o_ctl;
    logic [15:0] o_addr;

    always #5 clk = ~clk;

    mem_arb dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_word(cpu_word),
        .cpu_read(cpu_read), .cpu_dbus(cpu_dbus), .cpu_gnt(cpu_gnt),
        .dma_req(dma_req), .zero_req(zero_req), .dma_done(dma_done),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_word(ext_word),
        .ext_read(ext_read), .ext_gnt(ext_gnt),
        .mem_ce(mem_ce), .addr_nxt(addr_nxt), .word_nxt(word_nxt),
        .read_nxt(read_nxt), .dbus_nxt(dbus_nxt), .dma(dma), .owner(owner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        rst_n = 1'b1; rdy = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; zero_req = 1'b0;
        ext_req = 1'b0; cpu_word = 1'b1; cpu_read = 1'b1; cpu_dbus = 1'b0;
        ext_word = 1'b1; ext_read = 1'b1; cpu_addr = 16'h0; ext_addr = 16'h0;
    endtask

    // one clock: sample mid-cycle, compare to the model, advance the model
    task automatic cyc();
        bit          ext_on, busy, la, dd, ew, er, edb;
        int          win;
        logic [15:0] na, ea;
        logic [1:0]  eo;
        #5;
        o_ctl  = {mem_ce, cpu_gnt, dma_done, ext_gnt, dma, owner, word_nxt, read_nxt, dbus_nxt};
        o_addr = addr_nxt;
        ext_on = EXT_EN && ext_req;
        busy   = m_own != 0;
        la     = rst_n && (dma_req || cpu_req || ext_on) && (!busy || rdy);
        dd     = rst_n && m_own == 2 && rdy;
        na     = zero_req ? 16'h0000 : dd ? m_addr + 16'd2 : m_addr;
        if (dma_req && !(cpu_req && m_cnt >= 8)) win = 2;
        else if (cpu_req) win = 1;
        else if (ext_on) win = 3;
        else win = 0;
        ea  = !la ? 16'h0 : win == 2 ? na : win == 1 ? cpu_addr : ext_addr;
        ew  = !la || win == 2 ? 1'b1 : win == 1 ? cpu_word : ext_word;
        er  = !la || win == 2 ? 1'b1 : win == 1 ? cpu_read : ext_read;
        edb = la && win == 1 && cpu_dbus;
        eo  = rst_n ? 2'(m_own) : 2'd0;
        check("ctl", 32'(o_ctl), 32'({la, rst_n && m_own == 1 && rdy, dd,
              rst_n && m_own == 3 && rdy, rst_n && m_own == 2, eo, ew, er, edb}));
        check("addr", 32'(o_addr), 32'(ea));
        if (!rst_n) begin
            m_own = 0; m_cnt = 0; m_addr = 16'h0000;
        end else begin
            m_addr = na;
            if (la) begin
                m_cnt = win != 2 ? 0 : cpu_req ? m_cnt + 1 : m_cnt;
                m_own = win;
            end else if (busy && rdy) m_own = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        m_own = 0; m_cnt = 0; m_addr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        // reset state with requests pending
        dma_req = 1'b1; cpu_req = 1'b1;
        cyc();
        check("rst_ctl", 32'(o_ctl), 32'b00_0000_0110);
        check("rst_addr", 32'(o_addr), 32'h0);

        // CPU only, rdy two cycles after launch
        quiet(); cpu_req = 1'b1; cpu_addr = 16'h1234; cpu_dbus = 1'b1;
        cyc();
        check("cpu_ce", 32'(o_ctl[9]), 32'd1);
        check("cpu_addr", 32'(o_addr), 32'h1234);
        cpu_req = 1'b0;
        cyc();
        check("cpu_own", 32'(o_ctl[4:3]), 32'd1);
        rdy = 1'b1;
        cyc();
        check("cpu_gnt", 32'(o_ctl[8]), 32'd1);
        rdy = 1'b0;
        cyc();
        check("cpu_idle", 32'(o_ctl[9:3]), 32'd0);

        // DMA contention: 8 DMA launches, one CPU launch, DMA resumes
        quiet(); dma_req = 1'b1; cpu_req = 1'b1; rdy = 1'b1; cpu_addr = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("cont_ce", 32'(o_ctl[9]), 32'd1);
            check("cont_addr", 32'(o_addr), i < 8 ? 32'(2 * i) : i == 8 ? 32'hBEEF : 32'h0010);
        end

        // zero request coinciding with dma_done
        cpu_req = 1'b0; zero_req = 1'b1;
        cyc();
        check("zero_done", 32'(o_ctl[7]), 32'd1);
        check("zero_addr", 32'(o_addr), 32'h0000);
        zero_req = 1'b0;
        cyc();
        check("zero_next", 32'(o_addr), 32'h0002);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst_n    = $urandom_range(0, 39) != 0;
            rdy      = $urandom_range(0, 2) != 0;
            cpu_req  = $urandom_range(0, 1) == 1;
            dma_req  = $urandom_range(0, 2) != 0;
            zero_req = $urandom_range(0, 19) == 0;
            ext_req  = $urandom_range(0, 2) == 0;
            cpu_addr = 16'($urandom); ext_addr = 16'($urandom);
            cpu_word = 1'($urandom); cpu_read = 1'($urandom); cpu_dbus = 1'($urandom);
            ext_word = 1'($urandom); ext_read = 1'($urandom);
            cyc();
        end

        // reset in the middle of a CPU access
        quiet(); rdy = 1'b1;
        cyc();
        rdy = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h00AA;
        cyc();
        cyc();
        check("mid_own", 32'(o_ctl[4:3]), 32'd1);
        rst_n = 1'b0; rdy = 1'b1;
        cyc();
        check("mid_nognt", 32'(o_ctl[8]), 32'd0);
        quiet();
        cyc();
        check("mid_ctl", 32'(o_ctl), 32'b00_0000_0110);
        check("mid_addr", 32'(o_addr), 32'h0);

        // external requester alone
        quiet(); ext_req = 1'b1; ext_addr = 16'h4321; ext_word = 1'b0; ext_read = 1'b0;
        cyc();
        check("ext_ce", 32'(o_ctl[9]), 32'(EXT_EN));
        check("ext_addr", 32'(o_addr), EXT_EN ? 32'h4321 : 32'h0);
        cyc();
        check("ext_own", 32'(o_ctl[4:3]), EXT_EN ? 32'd3 : 32'd0);
        rdy = 1'b1; ext_req = 1'b0;
        cyc();
        check("ext_gnt", 32'(o_ctl[6]), 32'(EXT_EN));

        // DMA address wrap from FFFE to 0000
        quiet(); rst_n = 1'b0;
        cyc();
        quiet(); dma_req = 1'b1; rdy = 1'b1;
        for (int i = 0; i <= 32768; i++) begin
            cyc();
            if (i == 0) check("wrap_base", 32'(o_addr), 32'h0000);
            if (i == 32767) check("wrap_fffe", 32'(o_addr), 32'hFFFE);
            if (i == 32768) check("wrap_zero", 32'(o_addr), 32'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- W, 16, word width
- DMA_BASE, 16'h0000, DMA address after reset or zero request
- DMA_BURST, 8, maximum consecutive DMA accesses while the CPU is waiting
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, global clock
- rst_n, in, 1, reset; synchronous, active-low
- rdy, in, 1, current memory access ready
- cpu_req, in, 1, CPU access request
- cpu_addr, in, W, CPU address
- cpu_word, in, 1, CPU access is word wide
- cpu_read, in, 1, CPU access is a read
- cpu_dbus, in, 1, CPU access uses the on-chip data bus
- cpu_gnt, out, 1, CPU access-complete pulse
- dma_req, in, 1, DMA request
- zero_req, in, 1, reset the DMA address request
- dma_done, out, 1, DMA access-complete pulse
- ext_req, in, 1, external/debug access request
- ext_addr, in, W, external address
- ext_word, in, 1, external access is word wide
- ext_read, in, 1, external access is a read
- ext_gnt, out, 1, external access-complete pulse
- mem_ce, out, 1, launch the next access
- addr_nxt, out, W, next access address
- word_nxt, out, 1, next access is word wide
- read_nxt, out, 1, next access is a read
- dbus_nxt, out, 1, next access uses the on-chip data bus
- dma, out, 1, current access is a DMA transfer
- owner, out, 2, current owner: 0 idle, 1 CPU, 2 DMA, 3 external

Function
REQ-003 FSM states SHALL be IDLE, CPU, DMA and EXT; owner SHALL encode the current state.
REQ-004 A launch SHALL occur in any cycle where the FSM is in IDLE, or rdy=1 in a busy state, and at least one request is pending.
REQ-005 On a launch, mem_ce=1 in that same cycle, addr/word/read/dbus _nxt come combinationally from the winner, and the FSM enters the winner's state on the next edge.
REQ-006 With no request pending, IDLE SHALL hold; rdy=1 in a busy state with no request SHALL return the FSM to IDLE; mem_ce=0 otherwise.
REQ-007 Priority SHALL be DMA > CPU > EXT, except that after DMA_BURST consecutive DMA launches with cpu_req=1, the next launch goes to the CPU.
REQ-008 The burst counter SHALL clear on any non-DMA launch, and SHALL not count while cpu_req=0.
REQ-009 The complete pulse (cpu_gnt, dma_done or ext_gnt) SHALL be one cycle long, asserted in the cycle where rdy=1 and the FSM is in the owner's state; latency from launch to pulse SHALL be at least 1 cycle.
REQ-010 A requester SHALL hold its request and fields stable until its pulse; cpu_req dropping before the pulse has no effect on the access in flight.
REQ-011 A DMA access SHALL be a word read with dbus_nxt=0 and addr_nxt=dma_addr; dma=1 throughout the DMA state.
REQ-012 dma_addr SHALL increment by 2 (mod 2^W, wrapping from FFFE to 0000) on each dma_done.
REQ-013 zero_req=1 SHALL load DMA_BASE at the next edge; if it coincides with dma_done, the zero wins.
REQ-014 Back-to-back launches SHALL be supported with no idle cycle; a DMA-to-DMA back-to-back launch SHALL use the incremented address.

Reset
REQ-015 While rst_n=0 at a clk edge:
- state IDLE, dma_addr=DMA_BASE, burst counter 0
- all pulses 0, mem_ce 0, dma 0, owner 0
- word_nxt 1, read_nxt 1, dbus_nxt 0, addr_nxt 0
REQ-016 Reset in mid-access SHALL abandon the access without emitting a complete pulse.

Configuration
REQ-017 Macro MEM_ARB_EXT_EN:
- defined: the external requester is arbitrated per REQ-007.
- undefined: ext_* inputs are ignored, ext_gnt is tied 0, and EXT is unreachable.

Structure
REQ-018 Shared package mem_arb_pkg SHALL hold the owner/state encoding constants (OWN_IDLE, OWN_CPU, OWN_DMA, OWN_EXT).
REQ-019 Sub-module dma_addr_ctr SHALL hold the address counter, with increment, zero, DMA_BASE and wrap behaviour.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- CPU only: cpu_req=1, addr 1234, rdy 2 cycles later -> mem_ce in cycle 0, owner=1, cpu_gnt pulse in cycle 2, IDLE in cycle 3.
- DMA contention: dma_req and cpu_req held, rdy=1 every cycle, DMA_BURST=8 -> 8 DMA launches (addr 0000..000E), 1 CPU launch, then DMA resumes at 0010.
- Wrap: dma_addr=FFFE, dma_done -> next DMA addr_nxt=0000.
- Zero collision: zero_req and dma_done in the same cycle -> next DMA address = DMA_BASE.
- Mid-access reset: rst_n=0 in the CPU state before rdy -> no cpu_gnt, all outputs at reset values next cycle.
- Macro: with MEM_ARB_EXT_EN, ext_req alone -> owner=3 and an ext_gnt pulse; without it -> no launch, ext_gnt stays 0.
